// File: rtl/kbd_pkg.sv
// kbd_pkg: scan-code constants, decoder state and small lookup helpers
// shared by the keyboard front end.
package kbd_pkg;
   localparam logic [7:0] SC_BREAK = 8'hF0, SC_EXT = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12, SC_RSHIFT = 8'h59, SC_CAPS = 8'h58;
   localparam logic [7:0] SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74, SC_KP_ENTER = 8'h5A;
   localparam logic [7:0] ASC_UP = 8'h81, ASC_DOWN = 8'h82, ASC_LEFT = 8'h83, ASC_RIGHT = 8'h84, ASC_CR = 8'h0D;

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} kbd_state_t;

   function automatic logic [7:0] ext2ascii(input logic [7:0] code);
      case (code)
         SC_UP:       return ASC_UP;
         SC_DOWN:     return ASC_DOWN;
         SC_LEFT:     return ASC_LEFT;
         SC_RIGHT:    return ASC_RIGHT;
         SC_KP_ENTER: return ASC_CR;
         default:     return 8'h00;
      endcase
   endfunction

   function automatic logic is_letter(input logic [7:0] code);
      case (code)
         8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
         8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A:
            return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/kbd_scan2ascii.sv
// kbd_scan2ascii: set-2 make code plus shift to ASCII, 0x00 for unmapped keys
module kbd_scan2ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);
  logic [7:0] lo, hi;
  always_comb begin
    case (code)
      8'h1C: {lo, hi} = {"a", "A"};
      8'h32: {lo, hi} = {"b", "B"};
      8'h21: {lo, hi} = {"c", "C"};
      8'h23: {lo, hi} = {"d", "D"};
      8'h24: {lo, hi} = {"e", "E"};
      8'h2B: {lo, hi} = {"f", "F"};
      8'h34: {lo, hi} = {"g", "G"};
      8'h33: {lo, hi} = {"h", "H"};
      8'h43: {lo, hi} = {"i", "I"};
      8'h3B: {lo, hi} = {"j", "J"};
      8'h42: {lo, hi} = {"k", "K"};
      8'h4B: {lo, hi} = {"l", "L"};
      8'h3A: {lo, hi} = {"m", "M"};
      8'h31: {lo, hi} = {"n", "N"};
      8'h44: {lo, hi} = {"o", "O"};
      8'h4D: {lo, hi} = {"p", "P"};
      8'h15: {lo, hi} = {"q", "Q"};
      8'h2D: {lo, hi} = {"r", "R"};
      8'h1B: {lo, hi} = {"s", "S"};
      8'h2C: {lo, hi} = {"t", "T"};
      8'h3C: {lo, hi} = {"u", "U"};
      8'h2A: {lo, hi} = {"v", "V"};
      8'h1D: {lo, hi} = {"w", "W"};
      8'h22: {lo, hi} = {"x", "X"};
      8'h35: {lo, hi} = {"y", "Y"};
      8'h1A: {lo, hi} = {"z", "Z"};
      8'h16: {lo, hi} = {"1", "!"};
      8'h1E: {lo, hi} = {"2", "@"};
      8'h26: {lo, hi} = {"3", "#"};
      8'h25: {lo, hi} = {"4", "$"};
      8'h2E: {lo, hi} = {"5", "%"};
      8'h36: {lo, hi} = {"6", "^"};
      8'h3D: {lo, hi} = {"7", "&"};
      8'h3E: {lo, hi} = {"8", "*"};
      8'h46: {lo, hi} = {"9", "("};
      8'h45: {lo, hi} = {"0", ")"};
      8'h0E: {lo, hi} = {8'h60, "~"};
      8'h4E: {lo, hi} = {"-", "_"};
      8'h55: {lo, hi} = {"=", "+"};
      8'h54: {lo, hi} = {"[", "{"};
      8'h5B: {lo, hi} = {"]", "}"};
      8'h5D: {lo, hi} = {8'h5C, "|"};
      8'h4C: {lo, hi} = {";", ":"};
      8'h52: {lo, hi} = {8'h27, 8'h22};
      8'h41: {lo, hi} = {",", "<"};
      8'h49: {lo, hi} = {".", ">"};
      8'h4A: {lo, hi} = {"/", "?"};
      8'h29: {lo, hi} = {8'h20, 8'h20};
      8'h5A: {lo, hi} = {ASC_CR, ASC_CR};
      8'h66: {lo, hi} = {8'h08, 8'h08};
      8'h76: {lo, hi} = {8'h1B, 8'h1B};
      8'h0D: {lo, hi} = {8'h09, 8'h09};
      default: {lo, hi} = 16'h0000;
    endcase
    ascii = shift ? hi : lo;
  end
endmodule

// File: rtl/kbd_scan_decoder.sv
// kbd_scan_decoder: nibble-strobe PS/2 set-2 decoder with ASCII FIFO and int_req/int_ack.
// Optional caps lock under KBD_CAPSLOCK_EN.
module kbd_scan_decoder
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kbd_enb_hi,
   input  logic       kbd_enb_lo,
   input  logic [3:0] kbd_data,
   output logic       int_req,
   input  logic       int_ack,
   output logic [7:0] kbd_ascii,
   output logic       overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [SYNC_STAGES-1:0] hi_s, lo_s, ack_s;
   logic [3:0] data_s [SYNC_STAGES];
   logic hi_d, lo_d, ack_d, hi_edge, lo_edge, ack_edge;
   logic [3:0] hi_nib, data;
   logic hi_valid, byte_valid;
   logic [7:0] byte_q;
   kbd_state_t state, state_nx;
   logic make, brk, ext_make;
   logic lshift, rshift, shift, shift_eff;
   logic [7:0] s2a, char_nx;
   logic push, pop, full, wr_en;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_s <= '0;
         lo_s <= '0;
         ack_s <= '0;
         {hi_d, lo_d, ack_d} <= 3'b000;
         for (int i = 0; i < SYNC_STAGES; i++) data_s[i] <= 4'h0;
      end else begin
         hi_s <= {hi_s[SYNC_STAGES-2:0], kbd_enb_hi};
         lo_s <= {lo_s[SYNC_STAGES-2:0], kbd_enb_lo};
         ack_s <= {ack_s[SYNC_STAGES-2:0], int_ack};
         hi_d <= hi_s[SYNC_STAGES-1];
         lo_d <= lo_s[SYNC_STAGES-1];
         ack_d <= ack_s[SYNC_STAGES-1];
         data_s[0] <= kbd_data;
         for (int i = 1; i < SYNC_STAGES; i++) data_s[i] <= data_s[i-1];
      end
   end

   assign hi_edge  = hi_s[SYNC_STAGES-1] & ~hi_d;
   assign lo_edge  = lo_s[SYNC_STAGES-1] & ~lo_d;
   assign ack_edge = ack_s[SYNC_STAGES-1] & ~ack_d;
   assign data     = data_s[SYNC_STAGES-1];

   // A later hi strobe simply overwrites the pending high nibble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_nib <= 4'h0;
         hi_valid <= 1'b0;
         byte_q <= 8'h00;
         byte_valid <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (lo_edge && hi_valid) begin
            byte_q <= {hi_nib, data};
            byte_valid <= 1'b1;
            hi_valid <= 1'b0;
         end
         if (hi_edge) begin
            hi_nib <= data;
            hi_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (byte_valid)
         case (state)
            IDLE:    state_nx = byte_q == SC_BREAK ? BRK : byte_q == SC_EXT ? EXT : IDLE;
            EXT:     state_nx = byte_q == SC_BREAK ? EXT_BRK : IDLE;
            default: state_nx = IDLE;
         endcase
   end

   always_comb begin
      make     = byte_valid && state == IDLE && byte_q != SC_BREAK && byte_q != SC_EXT;
      brk      = byte_valid && state == BRK;
      ext_make = byte_valid && state == EXT && byte_q != SC_BREAK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lshift <= 1'b0;
         rshift <= 1'b0;
      end else begin
         if ((make || brk) && byte_q == SC_LSHIFT) lshift <= make;
         if ((make || brk) && byte_q == SC_RSHIFT) rshift <= make;
      end
   end

   assign shift = lshift | rshift;

`ifdef KBD_CAPSLOCK_EN
   logic caps;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) caps <= 1'b0;
      else if (make && byte_q == SC_CAPS) caps <= ~caps;
   end
   assign shift_eff = is_letter(byte_q) ? shift ^ caps : shift;
`else
   assign shift_eff = shift;
`endif

   kbd_scan2ascii u_s2a (.code(byte_q), .shift(shift_eff), .ascii(s2a));

   // Modifiers and caps map to 0x00 in the table, so they never enqueue
   assign char_nx = ext_make ? ext2ascii(byte_q) : make ? s2a : 8'h00;
   assign push    = char_nx != 8'h00;
   assign pop     = ack_edge && count != '0;
   assign full    = count == (AW+1)'(FIFO_DEPTH);
   assign wr_en   = push && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
         if (push && !wr_en) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= char_nx;
   end

   assign int_req   = count != '0;
   assign kbd_ascii = int_req ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_kbd_scan_decoder.sv
// tb_kbd_scan_decoder: directed vectors for kbd_scan_decoder with hand-computed results.
// Adds caps-lock vectors when KBD_CAPSLOCK_EN is defined.
module tb_kbd_scan_decoder;
   logic clk = 1'b0, rst = 1'b1;
   logic kbd_enb_hi = 1'b0, kbd_enb_lo = 1'b0, int_ack = 1'b0;
   logic [3:0] kbd_data = 4'h0;
   logic int_req, overflow;
   logic [7:0] kbd_ascii;
   int checks = 0, errors = 0;

   kbd_scan_decoder dut (
      .clk(clk), .rst(rst), .kbd_enb_hi(kbd_enb_hi), .kbd_enb_lo(kbd_enb_lo),
      .kbd_data(kbd_data), .int_req(int_req), .int_ack(int_ack),
      .kbd_ascii(kbd_ascii), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe_hi(input logic [3:0] n);
      kbd_data = n;
      tick(4);
      kbd_enb_hi = 1'b1;
      tick(4);
      kbd_enb_hi = 1'b0;
      tick(4);
   endtask

   task automatic strobe_lo(input logic [3:0] n);
      kbd_data = n;
      tick(4);
      kbd_enb_lo = 1'b1;
      tick(4);
      kbd_enb_lo = 1'b0;
      tick(4);
   endtask

   task automatic send_byte(input logic [7:0] b);
      strobe_hi(b[7:4]);
      strobe_lo(b[3:0]);
   endtask

   task automatic pop_one;
      int_ack = 1'b1;
      tick(4);
      int_ack = 1'b0;
      tick(4);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(2);
   endtask

   logic [7:0] digits [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   initial begin
      tick(2);
      check("rst_req", {7'd0, int_req}, 8'h00);
      check("rst_ascii", kbd_ascii, 8'h00);
      check("rst_ovf", {7'd0, overflow}, 8'h00);
      rst = 1'b0;
      tick(2);
      // latency: int_req rises on the 4th edge after lo rises
      strobe_hi(4'h1);
      kbd_data = 4'hC;
      tick(4);
      kbd_enb_lo = 1'b1;
      tick(3);
      check("lat_edge3", {7'd0, int_req}, 8'h00);
      tick(1);
      check("lat_edge4", {7'd0, int_req}, 8'h01);
      check("a_ascii", kbd_ascii, 8'h61);
      kbd_enb_lo = 1'b0;
      tick(4);
      pop_one();
      check("pop_req", {7'd0, int_req}, 8'h00);
      check("pop_ascii", kbd_ascii, 8'h00);
      // shift make/break
      send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0);
      send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
      check("shift_A", kbd_ascii, 8'h41);
      pop_one();
      check("shift_one", {7'd0, int_req}, 8'h00);
      send_byte(8'h1C);
      check("unshift_a", kbd_ascii, 8'h61);
      pop_one();
      // extended keys
      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      check("ext_up", kbd_ascii, 8'h81);
      pop_one();
      check("ext_one", {7'd0, int_req}, 8'h00);
      send_byte(8'hE0); send_byte(8'h11);
      check("ext_drop", {7'd0, int_req}, 8'h00);
      // fill and overflow
      check("ovf_pre", {7'd0, overflow}, 8'h00);
      for (int i = 0; i < 9; i++) send_byte(digits[i]);
      check("ovf_set", {7'd0, overflow}, 8'h01);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain%0d", i), kbd_ascii, 8'h31 + 8'(i));
         pop_one();
      end
      check("drain_empty", {7'd0, int_req}, 8'h00);
      check("ovf_sticky", {7'd0, overflow}, 8'h01);
      pop_one();
      check("pop_empty", kbd_ascii, 8'h00);
      // lo without hi, then last hi wins
      strobe_lo(4'hC);
      check("lo_only", {7'd0, int_req}, 8'h00);
      strobe_hi(4'h2);
      strobe_hi(4'h1);
      strobe_lo(4'hC);
      check("last_hi", kbd_ascii, 8'h61);
      pop_one();
      // reset mid-byte
      strobe_hi(4'h1);
      do_reset();
      strobe_lo(4'hC);
      check("midrst_req", {7'd0, int_req}, 8'h00);
      check("midrst_ascii", kbd_ascii, 8'h00);
      check("midrst_ovf", {7'd0, overflow}, 8'h00);
      send_byte(8'h16);
      check("after_rst", kbd_ascii, 8'h31);
      pop_one();
`ifdef KBD_CAPSLOCK_EN
      send_byte(8'h58);
      check("caps_noenq", {7'd0, int_req}, 8'h00);
      send_byte(8'h1C);
      check("caps_A", kbd_ascii, 8'h41);
      pop_one();
      send_byte(8'h16);
      check("caps_digit", kbd_ascii, 8'h31);
      pop_one();
      do_reset();
      send_byte(8'h58); send_byte(8'h12); send_byte(8'h1C);
      check("caps_shift_a", kbd_ascii, 8'h61);
      pop_one();
`else
      send_byte(8'h58);
      check("nocaps_drop", {7'd0, int_req}, 8'h00);
      send_byte(8'h1C);
      check("nocaps_a", kbd_ascii, 8'h61);
      pop_one();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
